branch_hazard_ctrl: RTL
=======================

# branch_hazard_ctrl

Pipeline sequencing controller for the 5-stage RISC-V core with branch prediction. It holds a table of 2-bit saturating branch predictors and supplies the IF-stage prediction. It detects load-use hazards and misprediction recovery, and drives stall, flush, redirect and the `noop` input of the main decoder. It also keeps branch and mispredict statistics counters for performance debug.

## Interface
Parameters:
- `IDX_W`, 4: predictor index width; table holds 2^IDX_W entries.
- `CNT_W`, 16: width of each statistics counter.

Ports:
- `clk_i`, in, 1: clock; all state updates on rising edge.
- `rst_i`, in, 1: reset, synchronous, active-high.
- `if_pc_i`, in, 32: PC of the instruction in IF.
- `if_is_branch_i`, in, 1: IF pre-decode flags the instruction as beq.
- `predict_taken_o`, out, 1: prediction for the IF branch.
- `id_rs1_i`, in, 5: rs1 field of the ID instruction.
- `id_rs2_i`, in, 5: rs2 field of the ID instruction.
- `ex_rd_i`, in, 5: rd of the EX instruction.
- `ex_memread_i`, in, 1: the EX instruction is a load.
- `ex_branch_i`, in, 1: a branch is resolving in EX this cycle.
- `ex_pc_i`, in, 32: PC of the resolving branch.
- `ex_taken_i`, in, 1: actual branch outcome.
- `ex_predicted_i`, in, 1: prediction carried down the pipe with that branch.
- `stall_o`, out, 1: hold PC and IF/ID.
- `noop_o`, out, 1: force bubble controls in the decoder.
- `flush_o`, out, 1: clear IF/ID and ID/EX.
- `redirect_o`, out, 1: PC mux selects the recovery target from EX.
- `branch_cnt_o`, out, CNT_W: number of resolved branches.
- `mispred_cnt_o`, out, CNT_W: number of mispredicted branches.

## Operation
**Predictor table**
- 2^IDX_W entries, each a 2-bit counter.
- Encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Index is PC[IDX_W+1:2] (word-aligned PCs).
- `predict_taken_o` = `if_is_branch_i` & entry[index(`if_pc_i`)][1]. Combinational.

**Table update**
- Happens on the clock edge when `ex_branch_i`=1, at index(`ex_pc_i`).
- Taken: counter increments, saturating at 11.
- Not taken: counter decrements, saturating at 00.

**Mispredict**
- Condition: `ex_branch_i` & (`ex_taken_i` != `ex_predicted_i`).
- Response: `flush_o`=1, `redirect_o`=1, `noop_o`=1, `stall_o`=0.

**Load-use hazard**
- Condition: `ex_memread_i` & `ex_rd_i`!=0 & (`ex_rd_i`==`id_rs1_i` | `ex_rd_i`==`id_rs2_i`).
- Response: `stall_o`=1, `noop_o`=1.

**Priority**
- Mispredict beats load-use, because the dependent ID instruction is being flushed anyway.
- In that case `stall_o`=0.

**Statistics counters**
- `branch_cnt_o` increments on each cycle with `ex_branch_i`=1.
- `mispred_cnt_o` increments on each mispredict.
- Both saturate at all-ones; no wrap.

**Reset**
- On a clock edge with `rst_i`=1:
  - every table entry becomes 01;
  - both counters become 0.
- While `rst_i`=1, all 1-bit outputs are forced to 0 and the counters read 0.
- Reset asserted mid-operation discards any pending update in that cycle. Reset has priority over update.

## Timing
- `predict_taken_o`, `stall_o`, `noop_o`, `flush_o` and `redirect_o` are combinational in the same cycle as their inputs, with zero latency.
- Table and counter updates become visible on the cycle after the edge.
- **Same-index read and update:** if `if_pc_i` and `ex_pc_i` map to one index in the same cycle, the prediction uses the pre-update value. The table is read before it is written.
- **Stall length:** a load-use stall lasts exactly one cycle. The next cycle the load is in MEM, the condition is no longer true, and `stall_o` drops.
- **Outputs at reset:** all outputs are 0 on the cycle after reset deasserts. From then on every predicted branch predicts not-taken until trained.
- **Illegal input:** `ex_predicted_i` is ignored when `ex_branch_i`=0.

## Test plan
- **Reset:** hold `rst_i` for 2 cycles, then query all 16 indices with `if_is_branch_i`=1 -> `predict_taken_o`=0 everywhere; both counters = 0.
- **Training:** resolve PC 0x40 taken twice -> entry goes 01 -> 10 -> 11, and `predict_taken_o` for `if_pc_i`=0x40 is 1 after the first update.
  - Four more taken resolutions -> entry stays 11.
  - Three not-taken resolutions -> entry goes 10, 01, 00.
- **Load-use:** `ex_memread_i`=1, `ex_rd_i`=5, `id_rs2_i`=5 -> `stall_o`=`noop_o`=1 for one cycle.
  - Same stimulus with `ex_rd_i`=0 -> no stall.
- **Mispredict plus load-use in the same cycle:** `ex_branch_i`=1, taken=1, predicted=0 -> `flush_o`=`redirect_o`=`noop_o`=1, `stall_o`=0; `mispred_cnt_o` increments by 1.
- **Same-index read/update:** `if_pc_i`=`ex_pc_i`=0x80, entry at 01, resolve taken -> `predict_taken_o` is 0 that cycle and 1 the next.
- **Saturation:** preload counters near all-ones via CNT_W=4 and issue 20 mispredicts -> both counters hold at 0xF.
  - Then assert `rst_i` mid-stream -> counters read 0 and the table is back to 01 the next cycle.

Source files
------------

// File: rtl/branch_hazard_ctrl.sv
// Pipeline sequencing controller: 2-bit branch predictor table, load-use and
// mispredict hazard detection, and saturating branch statistics counters.
module branch_hazard_ctrl #(
   parameter int unsigned IDX_W = 4,
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [31:0]      if_pc_i,
   input  logic             if_is_branch_i,
   output logic             predict_taken_o,
   input  logic [4:0]       id_rs1_i,
   input  logic [4:0]       id_rs2_i,
   input  logic [4:0]       ex_rd_i,
   input  logic             ex_memread_i,
   input  logic             ex_branch_i,
   input  logic [31:0]      ex_pc_i,
   input  logic             ex_taken_i,
   input  logic             ex_predicted_i,
   output logic             stall_o,
   output logic             noop_o,
   output logic             flush_o,
   output logic             redirect_o,
   output logic [CNT_W-1:0] branch_cnt_o,
   output logic [CNT_W-1:0] mispred_cnt_o
);

   localparam int unsigned Entries = 2 ** IDX_W;

   logic [1:0]       table_q [Entries];
   logic [1:0]       upd_entry;
   logic [1:0]       if_entry;
   logic [IDX_W-1:0] if_idx;
   logic [IDX_W-1:0] ex_idx;
   logic             mispredict;
   logic             load_use;
   logic [CNT_W-1:0] branch_cnt_q;
   logic [CNT_W-1:0] mispred_cnt_q;

   // Word-aligned PCs: drop the two byte-offset bits.
   assign if_idx   = if_pc_i[IDX_W+1:2];
   assign ex_idx   = ex_pc_i[IDX_W+1:2];
   // Read sees the pre-update value even when the same index is written this cycle.
   assign if_entry = table_q[if_idx];

   assign mispredict = ex_branch_i & (ex_taken_i != ex_predicted_i);
   assign load_use   = ex_memread_i & (ex_rd_i != 5'd0) &
                       ((ex_rd_i == id_rs1_i) | (ex_rd_i == id_rs2_i));

   // Saturating next value for the entry of the resolving branch.
   always_comb begin
      upd_entry = table_q[ex_idx];
      if (ex_taken_i) begin
         if (upd_entry != 2'b11) upd_entry = upd_entry + 2'b01;
      end else begin
         if (upd_entry != 2'b00) upd_entry = upd_entry - 2'b01;
      end
   end

   // Hazard outputs; mispredict wins over load-use since ID is flushed anyway.
   always_comb begin
      predict_taken_o = 1'b0;
      stall_o         = 1'b0;
      noop_o          = 1'b0;
      flush_o         = 1'b0;
      redirect_o      = 1'b0;
      if (!rst_i) begin
         predict_taken_o = if_is_branch_i & if_entry[1];
         flush_o         = mispredict;
         redirect_o      = mispredict;
         stall_o         = load_use & ~mispredict;
         noop_o          = mispredict | load_use;
      end
   end

   assign branch_cnt_o  = rst_i ? '0 : branch_cnt_q;
   assign mispred_cnt_o = rst_i ? '0 : mispred_cnt_q;

   // Predictor table: reset to weak-NT, train on each resolved branch.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int i = 0; i < Entries; i++) begin
            table_q[i] <= 2'b01;
         end
      end else if (ex_branch_i) begin
         table_q[ex_idx] <= upd_entry;
      end
   end

   // Statistics counters, saturating at all-ones.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         branch_cnt_q  <= '0;
         mispred_cnt_q <= '0;
      end else begin
         if (ex_branch_i && (branch_cnt_q != '1)) branch_cnt_q <= branch_cnt_q + 1'b1;
         if (mispredict && (mispred_cnt_q != '1)) mispred_cnt_q <= mispred_cnt_q + 1'b1;
      end
   end

endmodule
